// File: rtl/fifo_defs.sv
// Shared definitions for the async FIFO pointer blocks.
// Holds the default address width and the Gray-to-binary conversion.
// Contents: FIFO_ADDR_WIDTH default, gray2bin() helper.
package fifo_defs;

  // Default FIFO address width; depth = 2**FIFO_ADDR_WIDTH.
  localparam int FIFO_ADDR_WIDTH = 4;

  // Gray to binary: bit i of the result is the XOR of Gray bits MSB..i.
  // A log-step prefix XOR from the top covers any width up to 32 bits.
  // Callers zero-extend their Gray value in and size-cast the result back.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int shift = 1; shift < 32; shift = shift * 2) begin
      bin = bin ^ (bin >> shift);
    end
    return bin;
  endfunction

endpackage

// File: rtl/bin2gray.sv
// Binary to reflected-Gray encoder, purely combinational.
// Latency: zero cycles. Backpressure: none, a plain function of its input.
// Ports: bin (binary in), gray (Gray-coded out), both WIDTH bits.
module bin2gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = (bin >> 1) ^ bin;

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full/almost-full/level/overflow logic of an async FIFO.
// Latency: wen is combinational; wptr, wfull, wafull, wlevel, wovf are registered
//   and reflect a write on the same edge that accepts it.
// Backpressure: wfull holds wen low; a winc while full is dropped and flagged in wovf.
// Ports:
//   wclk, wrst_n     write clock, async active-low reset
//   winc             write request from the client
//   wq2_rptr         Gray read pointer, already synchronized into wclk
//   wen, waddr       memory write strobe and address
//   wptr             Gray write pointer for the read-domain synchronizer
//   wfull, wafull    full and almost-full flags
//   wlevel           fill level seen from the write side (pessimistic)
//   wovf             sticky overflow flag, cleared only by reset
module wptr_full_ctrl
  import fifo_defs::*;
#(
  parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
  // Fill level at or above which wafull asserts; legal 1..2**ADDR_WIDTH.
  parameter int AFULL_LEVEL = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  wafull,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  wovf
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AFULL_THR = PTR_W'(AFULL_LEVEL);

  logic [ADDR_WIDTH:0] wbin;
  logic [ADDR_WIDTH:0] wbin_next;
  logic [ADDR_WIDTH:0] wgray_next;
  logic [ADDR_WIDTH:0] rbin;
  logic [ADDR_WIDTH:0] rptr_full_pat;
  logic [ADDR_WIDTH:0] wlevel_next;
  logic                wfull_next;
  logic                wafull_next;
  logic                wovf_next;

  // Writes are accepted only while the registered full flag is clear.
  assign wen   = winc & ~wfull;
  assign waddr = wbin[ADDR_WIDTH-1:0];

  // Natural wrap modulo 2**PTR_W keeps the Gray sequence single-bit across 0.
  assign wbin_next = wbin + {{ADDR_WIDTH{1'b0}}, wen};

  bin2gray #(
    .WIDTH(PTR_W)
  ) u_bin2gray (
    .bin  (wbin_next),
    .gray (wgray_next)
  );

  // In Gray code, "exactly one lap ahead" means the top two bits are inverted
  // and the rest match. Comparing against the next pointer lets wfull assert
  // on the very edge that fills the last entry.
  assign rptr_full_pat = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1],
                          wq2_rptr[ADDR_WIDTH-2:0]};
  assign wfull_next    = (wgray_next == rptr_full_pat);

  // The synchronized read pointer lags the real one, so the level computed
  // here can only over-estimate occupancy; it never under-reports.
  assign rbin        = PTR_W'(gray2bin(32'(wq2_rptr)));
  assign wlevel_next = wbin_next - rbin;

  // AFULL_LEVEL never exceeds the depth, so a full FIFO already satisfies the
  // threshold; OR-ing wfull_next in keeps that invariant explicit.
  assign wafull_next = (wlevel_next >= AFULL_THR) | wfull_next;

  // A request that arrives while full is lost; remember it until reset.
  assign wovf_next = wovf | (winc & wfull);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      wafull <= 1'b0;
      wlevel <= '0;
      wovf   <= 1'b0;
    end else begin
      wbin   <= wbin_next;
      wptr   <= wgray_next;
      wfull  <= wfull_next;
      wafull <= wafull_next;
      wlevel <= wlevel_next;
      wovf   <= wovf_next;
    end
  end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl (ADDR_WIDTH=3, AFULL_LEVEL=6).
// Reference model: total accepted writes and total reads as plain integers;
// occupancy, address and Gray pointer are derived from those counts.
module tb_wptr_full_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;

  logic          wclk     = 1'b0;
  logic          wrst_n   = 1'b0;
  logic          winc     = 1'b0;
  logic [AW:0]   wq2_rptr = '0;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          wafull;
  logic [AW:0]   wlevel;
  logic          wovf;

  wptr_full_ctrl #(
    .ADDR_WIDTH  (AW),
    .AFULL_LEVEL (AFL)
  ) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .winc     (winc),
    .wq2_rptr (wq2_rptr),
    .wen      (wen),
    .waddr    (waddr),
    .wptr     (wptr),
    .wfull    (wfull),
    .wafull   (wafull),
    .wlevel   (wlevel),
    .wovf     (wovf)
  );

  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: counts are unbounded integers, never wrapped.
  int m_wr    = 0;
  int m_rd    = 0;
  bit m_full  = 1'b0;
  bit m_ovf   = 1'b0;
  bit seen_wrap = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Gray code of a count reduced modulo the pointer range (16).
  function automatic logic [3:0] gray4(input int n);
    int b;
    b = n % 16;
    return 4'(b ^ (b >> 1));
  endfunction

  task automatic model_reset();
    m_wr   = 0;
    m_rd   = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic check_regs();
    int lvl;
    lvl = m_wr - m_rd;
    chk("wptr",   wptr,   gray4(m_wr));
    chk("waddr",  waddr,  m_wr % DEPTH);
    chk("wfull",  wfull,  lvl == DEPTH);
    chk("wafull", wafull, lvl >= AFL);
    chk("wlevel", wlevel, lvl);
    chk("wovf",   wovf,   m_ovf);
  endtask

  // One write-clock cycle: drive at the falling edge, check the strobe,
  // then check registered state just after the rising edge.
  task automatic step(input bit w, input bit r);
    logic [AW:0] prev;
    bit acc;
    @(negedge wclk);
    winc = w;
    if (r && (m_rd < m_wr)) m_rd++;
    wq2_rptr = gray4(m_rd);
    #1;
    chk("wen", wen, w && !m_full);
    prev = wptr;
    @(posedge wclk);
    acc = w && !m_full;
    if (w && m_full) m_ovf = 1'b1;
    if (acc) m_wr++;
    m_full = ((m_wr - m_rd) == DEPTH);
    #1;
    check_regs();
    if (acc) begin
      chk("gray_hamming", $countones(wptr ^ prev), 1);
      if (prev == 4'b1000 && wptr == 4'b0000) seen_wrap = 1'b1;
    end
  endtask

  initial begin
    // Reset state while held.
    #1;
    check_regs();
    chk("rst_wen", wen, 0);
    repeat (2) @(posedge wclk);
    #2 wrst_n = 1'b1;

    // Advance to wbin=5, then assert reset between clock edges.
    repeat (5) step(1'b1, 1'b0);
    chk("pre_rst_waddr", waddr, 5);
    @(negedge wclk);
    #2;
    wrst_n   = 1'b0;
    winc     = 1'b0;
    wq2_rptr = '0;
    model_reset();
    #1;
    check_regs();
    chk("async_rst_wptr", wptr, 4'b0000);
    @(posedge wclk);
    #2 wrst_n = 1'b1;

    // Fill from empty; first write lands on the first edge after release.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0);
      if (i == AFL - 1) chk("afull_at_6", wafull, 1);
    end
    chk("fill_wptr", wptr, 4'b1100);
    chk("fill_level", wlevel, DEPTH);

    // Overflow: writes while full are dropped and flagged stickily.
    repeat (3) step(1'b1, 1'b0);
    chk("ovf_wptr", wptr, 4'b1100);
    chk("ovf_sticky", wovf, 1);

    // Drain one entry, then refill to full at address 0.
    step(1'b0, 1'b1);
    chk("drain_level", wlevel, 7);
    chk("drain_full", wfull, 0);
    step(1'b1, 1'b0);
    chk("refill_full", wfull, 1);

    // Simultaneous read advance and write at level 7.
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("simul_level", wlevel, 7);
    chk("simul_full", wfull, 0);

    // Drain down to level 2, then stream 40 writes holding the level there.
    while ((m_wr - m_rd) > 2) step(1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, (m_wr - m_rd) >= 2);
    chk("wrap_seen", seen_wrap, 1);
    chk("wrap_level", wlevel, 2);

    // Randomized traffic with phases biased toward full and toward empty.
    for (int i = 0; i < 600; i++) begin
      bit w;
      bit r;
      if ((i / 100) % 2 == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      step(w, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
